// File: rtl/led_pwm_fader.sv
// Purpose: turns each on/off bit of an LED pattern into a linear PWM fade on its pin.
// Latency: level_in to level_q takes 1 clk; brightness steps once per STEP_DIV enabled clks; led_out is registered.
// Backpressure: none; enable=0 freezes the ramp while the PWM keeps running.
// Optional build macro: LED_PWM_FADER_GAMMA_EN (gamma-corrected duty shadow load).
module led_pwm_fader #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] level_in,
  output logic [WIDTH-1:0] led_out,
  output logic             busy
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [WIDTH-1:0]                level_q;
  logic [PRE_W-1:0]                prescaler;
  logic [PWM_BITS-1:0]             pwm_cnt;
  logic [WIDTH-1:0][PWM_BITS-1:0]  bright;
  logic [WIDTH-1:0][PWM_BITS-1:0]  duty;
  logic [WIDTH-1:0][PWM_BITS-1:0]  duty_next;
  logic                            tick;
  logic                            pwm_wrap;
  logic                            busy_next;

  assign tick     = enable && (prescaler == PRE_LAST);
  assign pwm_wrap = (pwm_cnt == MAX);

  // Shadow-load value: linear brightness, or its square scaled back to PWM_BITS.
`ifdef LED_PWM_FADER_GAMMA_EN
  always_comb begin
    logic [2*PWM_BITS-1:0] sq;
    sq        = '0;
    duty_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sq = {{PWM_BITS{1'b0}}, bright[i]} * {{PWM_BITS{1'b0}}, bright[i]};
      // Full brightness must stay fully on; the plain square would land at MAX-1.
      duty_next[i] = (bright[i] == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    duty_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      duty_next[i] = bright[i];
    end
  end
`endif

  // Any channel whose brightness has not yet reached its target keeps busy high.
  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (level_q[i] ? (bright[i] != MAX) : (bright[i] != '0)) begin
        busy_next = 1'b1;
      end
    end
  end

  // Register the target pattern; the source shares this clock so no synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      level_q <= level_in;
    end
  end

  // Step-rate prescaler; holds its phase while fading is paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (enable) begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  // Free-running PWM period counter, independent of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Saturating one-step ramp toward 0 or MAX; reversal continues from the current value.
  always_ff @(posedge clk) begin
    if (reset) begin
      bright <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (level_q[i] && (bright[i] != MAX)) begin
          bright[i] <= bright[i] + PWM_BITS'(1);
        end else if (!level_q[i] && (bright[i] != '0)) begin
          bright[i] <= bright[i] - PWM_BITS'(1);
        end
      end
    end
  end

  // Duty shadow reloads only at the end of a PWM period so no period is ever truncated.
  // On a coincident tick this captures the pre-tick brightness.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty <= '0;
    end else if (pwm_wrap) begin
      duty <= duty_next;
    end
  end

  // Registered PWM compare; MAX is forced fully on instead of MAX of MAX+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        led_out[i] <= (duty[i] == MAX) || (pwm_cnt < duty[i]);
      end
    end
  end

  // Registered ramp-in-progress flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Purpose: randomized and directed scoreboard bench for led_pwm_fader (WIDTH=8, PWM_BITS=4, STEP_DIV=4).
// Latency: expected outputs are queued one per clock and checked half a clock later.
// Backpressure: not applicable; the DUT presents led_out/busy every cycle.
module tb_led_pwm_fader;

  localparam int W  = 8;
  localparam int PB = 4;
  localparam int SD = 4;
  localparam int MX = (1 << PB) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] level_in = '0;
  logic [W-1:0] led_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference state: target pattern, phase counters, brightness and duty per channel.
  int         m_lq [W];
  int         m_pre;
  int         m_pc;
  int         m_b  [W];
  int         m_d  [W];
  logic [W-1:0] m_led;
  logic         m_bz;

  logic [W:0] exp_q [$];

  led_pwm_fader #(.WIDTH(W), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .level_in (level_in),
    .led_out  (led_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Perceptual shaping of brightness into duty.
  function automatic int shape(input int b);
`ifdef LED_PWM_FADER_GAMMA_EN
    if (b == MX) return MX;
    return (b * b) / (MX + 1);
`else
    return b;
`endif
  endfunction

  // Advance the reference by one clock given the inputs seen on that edge.
  task automatic model_step(input logic r, input logic e, input logic [W-1:0] l);
    logic tk;
    if (r) begin
      m_pre = 0; m_pc = 0; m_led = '0; m_bz = 1'b0;
      for (int i = 0; i < W; i++) begin m_lq[i] = 0; m_b[i] = 0; m_d[i] = 0; end
    end else begin
      tk = e && (m_pre == SD - 1);
      m_bz = 1'b0;
      for (int i = 0; i < W; i++) begin
        m_led[i] = (m_d[i] == MX) || (m_pc < m_d[i]);
        if (m_lq[i] != 0 ? m_b[i] != MX : m_b[i] != 0) m_bz = 1'b1;
      end
      if (m_pc == MX)
        for (int i = 0; i < W; i++) m_d[i] = shape(m_b[i]);
      if (tk)
        for (int i = 0; i < W; i++) begin
          if (m_lq[i] != 0 && m_b[i] < MX) m_b[i] = m_b[i] + 1;
          else if (m_lq[i] == 0 && m_b[i] > 0) m_b[i] = m_b[i] - 1;
        end
      if (e) m_pre = (m_pre + 1) % SD;
      m_pc = (m_pc + 1) % (MX + 1);
      for (int i = 0; i < W; i++) m_lq[i] = int'(l[i]);
    end
    exp_q.push_back({m_led, m_bz});
  endtask

  // One clock of stimulus: drive on the falling edge, model the rising edge, queue the expectation.
  task automatic cyc(input logic r, input logic e, input logic [W-1:0] l);
    @(negedge clk);
    reset = r; enable = e; level_in = l;
    @(posedge clk);
    #1;
    model_step(r, e, l);
  endtask

  // Run with fixed inputs until the reference brightness of one channel hits a value.
  task automatic run_until(input int ch, input int val, input logic [W-1:0] l, input string tag);
    int n;
    n = 0;
    while (m_b[ch] != val && n < 400) begin
      cyc(1'b0, 1'b1, l);
      n++;
    end
    total++;
    if (m_b[ch] != val) begin
      bad++;
      $display("FAIL %s: brightness ch%0d=%0d required %0d", tag, ch, m_b[ch], val);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({led_out, busy} !== e) begin
          bad++;
          $display("FAIL outputs @%0t: led_out=%h busy=%b required led_out=%h busy=%b",
                   $time, led_out, busy, e[W:1], e[0]);
        end
      end
    end
  end

  initial begin
    int hi;
    logic [W-1:0] lv;
    int len;

    // Reset held two cycles with all targets high.
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hFF);

    // Fade-in channel 0 to full, then dwell so it is constant on.
    run_until(0, MX, 8'h01, "fade_in");
    repeat (40) cyc(1'b0, 1'b1, 8'h01);

    // Mid-fade reversal from 6 back to dark.
    cyc(1'b1, 1'b1, 8'h00);
    run_until(0, 6, 8'h01, "rev_up");
    run_until(0, 0, 8'h00, "rev_down");
    repeat (40) cyc(1'b0, 1'b1, 8'h00);

    // Duty check: freeze at 5 and count high cycles over one aligned-or-not period.
    run_until(0, 5, 8'h01, "duty_up");
    repeat (32) cyc(1'b0, 1'b0, 8'h01);
    hi = 0;
    for (int k = 0; k <= MX; k++) begin
      cyc(1'b0, 1'b0, 8'h01);
      if (led_out[0]) hi++;
    end
    total++;
    if (hi != shape(5)) begin
      bad++;
      $display("FAIL duty_count: high cycles=%0d required %0d", hi, shape(5));
    end

    // Long enable hold mid-fade, then resume to completion.
    repeat (100) cyc(1'b0, 1'b0, 8'h01);
    run_until(0, MX, 8'h01, "resume");
    repeat (20) cyc(1'b0, 1'b1, 8'h01);

    // Reset mid-fade on channel 3, then restart from dark.
    cyc(1'b1, 1'b1, 8'h08);
    run_until(3, 9, 8'h08, "ch3_up");
    cyc(1'b1, 1'b1, 8'h08);
    run_until(3, 8, 8'h08, "ch3_restart");
    repeat (32) cyc(1'b0, 1'b0, 8'h08);
    run_until(3, MX, 8'h08, "ch3_full");
    repeat (40) cyc(1'b0, 1'b1, 8'h08);

    // Randomized patterns, pauses and occasional resets.
    for (int s = 0; s < 50; s++) begin
      lv  = W'($urandom);
      len = $urandom_range(5, 90);
      for (int k = 0; k < len; k++)
        cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), lv);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
